// File: rtl/uart_tx_fifo_gen.sv
// uart_tx_fifo_gen
//   UART transmitter fed by an internal write FIFO. Host byte writes are queued
//   and sent as frames: start bit, DATA_BITS data bits LSB first, an optional
//   parity bit, then STOP_BITS stop bits. Each bit lasts exactly
//   DIV = round(CLK_FREQ / BAUD) clocks. Back-to-back frames have no idle gap.
//
//   Optional feature macro: UART_TX_PARITY_EN
//     defined   -> a parity bit follows the data bits; even parity, or odd
//                  parity when PARITY_ODD = 1
//     undefined -> no parity bit; PARITY_ODD is ignored
//
//   DIV must be at least 2.
//
// Ports
//   clk        in   system clock
//   rst        in   synchronous active-high reset (aborts the frame and empties the FIFO)
//   wr_en      in   write strobe
//   wr_data    in   word to queue (DATA_BITS wide)
//   full       out  FIFO holds 2**FIFO_AW words
//   level      out  words queued, excluding the frame in flight
//   overflow   out  sticky flag: a write arrived while full (cleared only by rst)
//   busy       out  transmitter is not idle
//   tx_done    out  one-clock pulse on the last clock of each frame
//   uart_tx_o  out  serial line, idle high

module uart_tx_fifo_gen #(
    parameter int CLK_FREQ   = 50_000_000,
    parameter int BAUD       = 115200,
    parameter int DATA_BITS  = 8,
    parameter int STOP_BITS  = 1,
    parameter int FIFO_AW    = 4,
    parameter int PARITY_ODD = 0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 wr_en,
    input  logic [DATA_BITS-1:0] wr_data,
    output logic                 full,
    output logic [FIFO_AW:0]     level,
    output logic                 overflow,
    output logic                 busy,
    output logic                 tx_done,
    output logic                 uart_tx_o
);

    localparam int DIV   = (CLK_FREQ + BAUD / 2) / BAUD;
    localparam int DEPTH = 2 ** FIFO_AW;
    localparam int CW    = $clog2(DIV + 1);

    localparam logic [CW-1:0]    DIV_LAST  = CW'(DIV - 1);
    localparam logic [CW-1:0]    DIV_PEN   = CW'(DIV - 2);
    localparam logic [3:0]       DATA_LAST = 4'(DATA_BITS - 1);
    localparam logic [3:0]       STOP_LAST = 4'(STOP_BITS - 1);
    localparam logic [FIFO_AW:0] DEPTH_C   = (FIFO_AW + 1)'(DEPTH);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
`ifdef UART_TX_PARITY_EN
        PARITY,
`endif
        STOP
    } state_t;

    state_t               state;
    logic [CW-1:0]        baud_cnt;
    logic [3:0]           bit_cnt;
    logic [DATA_BITS-1:0] shreg;

    logic [DATA_BITS-1:0] mem [DEPTH];
    logic [FIFO_AW-1:0]   wr_ptr;
    logic [FIFO_AW-1:0]   rd_ptr;
    logic [FIFO_AW:0]     count;

    logic wr_ok;
    logic pop;
    logic bit_end;
    logic frame_end;

    assign level     = count;
    assign full      = (count == DEPTH_C);
    assign wr_ok     = wr_en && !full;
    assign bit_end   = (baud_cnt == DIV_LAST);
    assign frame_end = (state == STOP) && bit_end && (bit_cnt == STOP_LAST);
    // A pop happens from IDLE, or on the edge closing a frame so the next
    // start bit follows the last stop bit directly.
    assign pop       = (count != '0) && ((state == IDLE) || frame_end);

`ifdef UART_TX_PARITY_EN
    logic par_bit;
    function automatic logic calc_parity(input logic [DATA_BITS-1:0] w);
        return (PARITY_ODD != 0) ? ~^w : ^w;
    endfunction
`else
    logic unused_parity_odd;
    assign unused_parity_odd = 1'(PARITY_ODD);
`endif

    // FIFO storage; data only, never reset.
    always_ff @(posedge clk) begin
        if (wr_ok) mem[wr_ptr] <= wr_data;
    end

    // FIFO control. A write while full is dropped even when a pop frees a slot
    // in the same cycle, because full comes from the registered count.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (wr_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop)   rd_ptr <= rd_ptr + 1'b1;
            case ({wr_ok, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (wr_en && full) overflow <= 1'b1;
        end
    end

    // Transmit FSM; uart_tx_o is registered and always holds the bit of the
    // state being entered.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            baud_cnt  <= '0;
            bit_cnt   <= '0;
            uart_tx_o <= 1'b1;
            busy      <= 1'b0;
            tx_done   <= 1'b0;
        end else begin
            // Raised one clock early so the pulse lands on the final stop clock.
            tx_done <= (state == STOP) && (bit_cnt == STOP_LAST) && (baud_cnt == DIV_PEN);

            case (state)
                IDLE: begin
                    baud_cnt <= '0;
                    bit_cnt  <= '0;
                    if (pop) begin
                        shreg     <= mem[rd_ptr];
`ifdef UART_TX_PARITY_EN
                        par_bit   <= calc_parity(mem[rd_ptr]);
`endif
                        state     <= START;
                        uart_tx_o <= 1'b0;
                        busy      <= 1'b1;
                    end
                end

                START: begin
                    if (bit_end) begin
                        state     <= DATA;
                        baud_cnt  <= '0;
                        bit_cnt   <= '0;
                        uart_tx_o <= shreg[0];
                        shreg     <= shreg >> 1;
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end

                DATA: begin
                    if (bit_end) begin
                        baud_cnt <= '0;
                        if (bit_cnt == DATA_LAST) begin
                            bit_cnt   <= '0;
`ifdef UART_TX_PARITY_EN
                            state     <= PARITY;
                            uart_tx_o <= par_bit;
`else
                            state     <= STOP;
                            uart_tx_o <= 1'b1;
`endif
                        end else begin
                            bit_cnt   <= bit_cnt + 1'b1;
                            uart_tx_o <= shreg[0];
                            shreg     <= shreg >> 1;
                        end
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end

`ifdef UART_TX_PARITY_EN
                PARITY: begin
                    if (bit_end) begin
                        state     <= STOP;
                        baud_cnt  <= '0;
                        bit_cnt   <= '0;
                        uart_tx_o <= 1'b1;
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
`endif

                STOP: begin
                    if (bit_end) begin
                        baud_cnt <= '0;
                        if (bit_cnt == STOP_LAST) begin
                            bit_cnt <= '0;
                            if (pop) begin
                                shreg     <= mem[rd_ptr];
`ifdef UART_TX_PARITY_EN
                                par_bit   <= calc_parity(mem[rd_ptr]);
`endif
                                state     <= START;
                                uart_tx_o <= 1'b0;
                            end else begin
                                state     <= IDLE;
                                uart_tx_o <= 1'b1;
                                busy      <= 1'b0;
                            end
                        end else begin
                            bit_cnt <= bit_cnt + 1'b1;
                        end
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end

                default: begin
                    state     <= IDLE;
                    uart_tx_o <= 1'b1;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule
